pipe_stage_reg: RTL

- Generic parametrised pipeline-stage register, successor to the fixed-field inter-stage registers. Usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries an opaque data bus and a control bus with a valid/ready handshake, so stalls propagate by backpressure instead of per-stage enables.
- Flush injects a configurable NOP control word. A saturating counter records output bubbles for hazard-rate profiling.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 54 +++++
 rtl/pipe_stage_reg.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for pipe_stage_reg.
// FULL exists only when PIPE_STAGE_SKID_EN is defined.
package pipe_pkg;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} pipe_state_e;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1} pipe_state_e;
`endif

  // Replicated to CTRL_W bits to form the default NOP control word
  localparam logic CTRL_NOP_BIT = 1'b0;

  // Saturating increment for counters up to 32 bits wide
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data+ctrl holding register with load, clear-to-NOP and hold.
module pipe_slot #(
  parameter int unsigned       DATA_W   = 128,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;

  // Clear wins over load
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = CTRL_NOP;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_NOP;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline-stage register with flush-to-NOP and bubble counter.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = 128,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{CTRL_NOP_BIT}},
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              bubble_clr
);

  pipe_state_e       state_d, state_q;
  logic              in_xfer, out_xfer;
  logic              main_load, main_clr;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic [CNT_W-1:0]  bubble_d, bubble_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_main (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .data_i  (main_src_data),
    .ctrl_i  (main_src_ctrl),
    .valid_o (out_valid),
    .data_o  (out_data),
    .ctrl_o  (out_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load, skid_clr, skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Decoded from state flops only; no path from out_ready
  assign in_ready = rst_n && (state_q != FULL);

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_NOP (CTRL_NOP)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    main_src_data = in_data;
    main_src_ctrl = in_ctrl;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer && skid_valid) begin
            main_load     = 1'b1;
            main_src_data = skid_data;
            main_src_ctrl = skid_ctrl;
            skid_clr      = 1'b1;
            state_d       = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end
`else
  assign in_ready = rst_n && (!out_valid || out_ready);

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_src_data = in_data;
    main_src_ctrl = in_ctrl;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end
`endif

  always_comb begin
    bubble_d = bubble_q;
    if (bubble_clr) begin
      bubble_d = '0;
    end else if (!out_valid) begin
      bubble_d = CNT_W'(sat_inc(32'(bubble_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;

endmodule
